// File: rtl/vga_pkg.sv
// XGA 1024x768 @ 60 Hz raster geometry and the timing bus shared by the video pipeline.
package vga_pkg;

    // Counter width for both raster axes
    localparam int COUNT_WIDTH = 11;

    // Horizontal geometry in pixel clocks
    localparam int VISIBLE_WIDTH          = 1024;
    localparam int HORIZONTAL_FRONT_PORCH = 24;
    localparam int HORIZONTAL_SYNC_PULSE  = 136;
    localparam int HORIZONTAL_BACK_PORCH  = 160;
    localparam int FULL_WIDTH = VISIBLE_WIDTH + HORIZONTAL_FRONT_PORCH
                              + HORIZONTAL_SYNC_PULSE + HORIZONTAL_BACK_PORCH;

    // Vertical geometry in lines
    localparam int VISIBLE_HEIGHT        = 768;
    localparam int VERTICAL_FRONT_PORCH  = 3;
    localparam int VERTICAL_SYNC_PULSE   = 6;
    localparam int VERTICAL_BACK_PORCH   = 29;
    localparam int FULL_HEIGHT = VISIBLE_HEIGHT + VERTICAL_FRONT_PORCH
                               + VERTICAL_SYNC_PULSE + VERTICAL_BACK_PORCH;

    // Sync windows, half-open [START, STOP)
    localparam int HSYNC_START = VISIBLE_WIDTH + HORIZONTAL_FRONT_PORCH;
    localparam int HSYNC_STOP  = HSYNC_START + HORIZONTAL_SYNC_PULSE;
    localparam int VSYNC_START = VISIBLE_HEIGHT + VERTICAL_FRONT_PORCH;
    localparam int VSYNC_STOP  = VSYNC_START + VERTICAL_SYNC_PULSE;

    // Timing bus consumed by background, rect and char overlay stages
    typedef struct packed {
        logic [COUNT_WIDTH-1:0] hcount;
        logic                   hsync;
        logic                   hblnk;
        logic [COUNT_WIDTH-1:0] vcount;
        logic                   vsync;
        logic                   vblnk;
    } vga_bus_t;

endpackage

// File: rtl/vga_timing.sv
// Free-running raster timing generator. Counters and flags are all registered;
// flags are loaded from the next-state counters so they line up with the
// counters in the same cycle.
module vga_timing
    import vga_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    output logic [COUNT_WIDTH-1:0] hcount,
    output logic                   hsync,
    output logic                   hblnk,
    output logic [COUNT_WIDTH-1:0] vcount,
    output logic                   vsync,
    output logic                   vblnk
);

    localparam logic [COUNT_WIDTH-1:0] H_LAST   = COUNT_WIDTH'(FULL_WIDTH - 1);
    localparam logic [COUNT_WIDTH-1:0] V_LAST   = COUNT_WIDTH'(FULL_HEIGHT - 1);
    localparam logic [COUNT_WIDTH-1:0] H_VIS    = COUNT_WIDTH'(VISIBLE_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] V_VIS    = COUNT_WIDTH'(VISIBLE_HEIGHT);
    localparam logic [COUNT_WIDTH-1:0] HS_START = COUNT_WIDTH'(HSYNC_START);
    localparam logic [COUNT_WIDTH-1:0] HS_STOP  = COUNT_WIDTH'(HSYNC_STOP);
    localparam logic [COUNT_WIDTH-1:0] VS_START = COUNT_WIDTH'(VSYNC_START);
    localparam logic [COUNT_WIDTH-1:0] VS_STOP  = COUNT_WIDTH'(VSYNC_STOP);
    localparam logic [COUNT_WIDTH-1:0] ONE      = COUNT_WIDTH'(1);

    logic [COUNT_WIDTH-1:0] h_q, v_q;
    logic [COUNT_WIDTH-1:0] h_nxt, v_nxt;

    assign hcount = h_q;
    assign vcount = v_q;

    // Next raster position; out-of-range values (unreachable) also fold back to 0
    always_comb begin
        h_nxt = h_q + ONE;
        v_nxt = v_q;
        if (h_q >= H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_q >= V_LAST) ? '0 : v_q + ONE;
        end
    end

    // Horizontal counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) h_q <= '0;
        else     h_q <= h_nxt;
    end

    // Vertical counter, moves only on the line wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) v_q <= '0;
        else     v_q <= v_nxt;
    end

    // Sync and blanking flags, decoded from the position being loaded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync <= 1'b0;
            hblnk <= 1'b0;
            vsync <= 1'b0;
            vblnk <= 1'b0;
        end else begin
            hblnk <= (h_nxt >= H_VIS);
            hsync <= (h_nxt >= HS_START) && (h_nxt < HS_STOP);
            vblnk <= (v_nxt >= V_VIS);
            vsync <= (v_nxt >= VS_START) && (v_nxt < VS_STOP);
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a position-based reference model (linear pixel index
// within the frame) predicts the whole bus each cycle. Internal counters are
// forced to jump to regions far into the frame so the vertical edges are
// reachable in a short run.
`timescale 1ns/1ps
module tb_vga_timing;

    localparam int FW    = 1344;
    localparam int FH    = 806;
    localparam int FRAME = FW * FH;

    logic        clk, rst;
    logic [10:0] hcount, vcount;
    logic        hsync, hblnk, vsync, vblnk;

    int nerr = 0;
    int nchk = 0;
    int pos  = 0;
    logic [10:0] jh, jv;
    logic [25:0] obs, expv;

    vga_timing dut (
        .clk(clk), .rst(rst),
        .hcount(hcount), .hsync(hsync), .hblnk(hblnk),
        .vcount(vcount), .vsync(vsync), .vblnk(vblnk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: bus for linear frame position p
    function automatic logic [25:0] model(int p);
        int h, v;
        logic hs, hb, vs, vb;
        h  = p % FW;
        v  = (p / FW) % FH;
        hb = (h >= 1024);
        hs = (h >= 1048) && (h < 1184);
        vb = (v >= 768);
        vs = (v >= 771) && (v < 777);
        return {11'(h), hs, hb, 11'(v), vs, vb};
    endfunction

    function automatic logic [25:0] bus();
        return {hcount, hsync, hblnk, vcount, vsync, vblnk};
    endfunction

    // One active edge; model advances; sample on the falling edge
    task automatic tick();
        @(posedge clk);
        pos = (pos + 1) % FRAME;
        @(negedge clk);
    endtask

    // Jump the raster to (h,v) between edges; outputs are valid after next edge
    task automatic jump(input int h, input int v);
        jh = 11'(h);
        jv = 11'(v);
        force dut.h_q = jh;
        force dut.v_q = jv;
        #1;
        release dut.h_q;
        release dut.v_q;
        pos = v * FW + h;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pos = 0;
        n = $urandom_range(200, 1500);
        repeat (n) tick();
        obs = bus(); expv = model(pos); nchk++;
        if (obs !== expv) begin nerr++; $display("FAIL reset_prerun got=%h exp=%h", obs, expv); end
        #2 rst = 1'b1;
        #1;
        obs = bus(); nchk++;
        if (obs !== 26'd0) begin nerr++; $display("FAIL reset_async got=%h exp=0", obs); end
        repeat (3) @(posedge clk);
        #1;
        obs = bus(); nchk++;
        if (obs !== 26'd0) begin nerr++; $display("FAIL reset_hold got=%h exp=0", obs); end
        @(negedge clk);
        rst = 1'b0;
        pos = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            nchk++;
            if (hcount !== 11'(i)) begin nerr++; $display("FAIL reset_restart hcount=%0d exp=%0d", hcount, i); end
            obs = bus(); expv = model(pos); nchk++;
            if (obs !== expv) begin nerr++; $display("FAIL reset_restart_bus got=%h exp=%h", obs, expv); end
        end
    endtask

    task automatic test_horizontal();
        jump(1020, $urandom_range(0, 700));
        repeat (170) begin
            tick();
            obs = bus(); expv = model(pos); nchk++;
            if (obs !== expv) begin nerr++; $display("FAIL horiz h=%0d got=%h exp=%h", pos % FW, obs, expv); end
        end
    endtask

    task automatic test_line_wrap();
        jump(1341, 5);
        tick();
        tick();
        nchk++;
        if (hcount !== 11'd1343 || vcount !== 11'd5) begin
            nerr++; $display("FAIL line_wrap_pre h=%0d v=%0d exp=1343,5", hcount, vcount);
        end
        tick();
        nchk++;
        if (hcount !== 11'd0 || vcount !== 11'd6 || hblnk !== 1'b0) begin
            nerr++; $display("FAIL line_wrap h=%0d v=%0d hblnk=%b exp=0,6,0", hcount, vcount, hblnk);
        end
    endtask

    task automatic test_vertical();
        int lines [7] = '{766, 767, 769, 770, 775, 776, 777};
        foreach (lines[k]) begin
            jump(1340, lines[k]);
            repeat (6) begin
                tick();
                obs = bus(); expv = model(pos); nchk++;
                if (obs !== expv) begin
                    nerr++; $display("FAIL vert h=%0d v=%0d got=%h exp=%h", pos % FW, pos / FW, obs, expv);
                end
            end
        end
    endtask

    task automatic test_frame_wrap();
        jump(1340, 805);
        repeat (3) tick();
        tick();
        nchk++;
        if (hcount !== 11'd0 || vcount !== 11'd0 || vblnk !== 1'b0 || vsync !== 1'b0 || hblnk !== 1'b0) begin
            nerr++; $display("FAIL frame_wrap h=%0d v=%0d vblnk=%b exp=0,0,0", hcount, vcount, vblnk);
        end
        tick();
        obs = bus(); expv = model(pos); nchk++;
        if (obs !== expv) begin nerr++; $display("FAIL frame_wrap_next got=%h exp=%h", obs, expv); end
    endtask

    task automatic test_period();
        int cyc, last, nrise, len;
        logic prev;
        cyc = 0; last = -1; nrise = 0; prev = hsync;
        while (nrise < 4 && cyc < 6 * FW) begin
            tick();
            cyc++;
            if (hsync && !prev) begin
                if (last >= 0) begin
                    nchk++;
                    if (cyc - last !== FW) begin nerr++; $display("FAIL hsync_period got=%0d exp=%0d", cyc - last, FW); end
                end
                last = cyc;
                nrise++;
            end
            prev = hsync;
        end
        nchk++;
        if (nrise < 4) begin nerr++; $display("FAIL hsync_rises got=%0d exp=4", nrise); end
        // vsync high time across one frame
        jump(1340, 770);
        tick();
        len = 0; cyc = 0;
        while (!vsync && cyc < 2 * FW) begin tick(); cyc++; end
        nchk++;
        if (hcount !== 11'd0 || vcount !== 11'd771) begin
            nerr++; $display("FAIL vsync_rise_pos h=%0d v=%0d exp=0,771", hcount, vcount);
        end
        while (vsync && len < 9000) begin tick(); len++; end
        nchk++;
        if (len !== 6 * FW) begin nerr++; $display("FAIL vsync_width got=%0d exp=%0d", len, 6 * FW); end
        nchk++;
        if (hcount !== 11'd0 || vcount !== 11'd777) begin
            nerr++; $display("FAIL vsync_fall_pos h=%0d v=%0d exp=0,777", hcount, vcount);
        end
    endtask

    task automatic test_midframe_reset();
        int len;
        jump(598, 400);
        tick();
        tick();
        nchk++;
        if (hcount !== 11'd600 || vcount !== 11'd400) begin
            nerr++; $display("FAIL mid_pos h=%0d v=%0d exp=600,400", hcount, vcount);
        end
        #2 rst = 1'b1;
        #1;
        obs = bus(); nchk++;
        if (obs !== 26'd0) begin nerr++; $display("FAIL mid_reset got=%h exp=0", obs); end
        @(negedge clk);
        rst = 1'b0;
        pos = 0;
        len = 0;
        do begin tick(); len++; end while (hcount !== 11'd0 && len < 2000);
        nchk++;
        if (len !== FW) begin nerr++; $display("FAIL mid_first_line got=%0d exp=%0d", len, FW); end
        nchk++;
        if (vcount !== 11'd1) begin nerr++; $display("FAIL mid_vcount got=%0d exp=1", vcount); end
    endtask

    task automatic test_random();
        int n;
        repeat (25) begin
            jump($urandom_range(0, FW - 1), $urandom_range(0, FH - 1));
            n = $urandom_range(1, 60);
            repeat (n) begin
                tick();
                obs = bus(); expv = model(pos); nchk++;
                if (obs !== expv) begin
                    nerr++; $display("FAIL random h=%0d v=%0d got=%h exp=%h", pos % FW, pos / FW, obs, expv);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_horizontal();
        test_line_wrap();
        test_vertical();
        test_frame_wrap();
        test_period();
        test_midframe_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
